// File: rtl/param_sine_nco.sv
// Parametrised sine NCO: phase accumulator -> quarter-wave mirrored table -> signed sample, 3 enabled edges of latency.
// Define COS_OUTPUT_EN to add the quadrature o_cosine output, which shares o_valid.
module param_sine_nco #(
    parameter int ACC_W    = 32,
    parameter int THETA_W  = 10,
    parameter int OUT_W    = 24,
    parameter     ROM_FILE = "sine_quarter.mem"
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_clkEn,
    input  logic                      i_load,
    input  logic [ACC_W-1:0]          i_freqWord,
    input  logic [THETA_W-1:0]        i_phaseOffset,
    input  logic                      i_sync,
    output logic signed [OUT_W-1:0]   o_sine,
`ifdef COS_OUTPUT_EN
    output logic signed [OUT_W-1:0]   o_cosine,
`endif
    output logic [THETA_W-1:0]        o_theta,
    output logic                      o_valid
);

    localparam int  A_W      = THETA_W - 2;
    localparam int  N        = 1 << A_W;
    localparam int  SAMP_W   = OUT_W - 1;
    localparam int  ROM_BITS = N * SAMP_W;
    localparam int  IDX_W    = $clog2(ROM_BITS);
    localparam real PI       = 3.14159265358979323846;

    // Quarter-wave table sampled at half-step offsets, built at elaboration with the same formula as the ROM_FILE image.
    function automatic logic [ROM_BITS-1:0] buildTable();
        logic [ROM_BITS-1:0] tbl;
        logic [IDX_W-1:0]    base;
        real                 amp;
        real                 ang;
        real                 term;
        real                 sum;
        tbl = '0;
        amp = 1.0;
        for (int i = 0; i < SAMP_W; i++) amp = amp * 2.0;
        amp = amp - 1.0;
        for (int k = 0; k < N; k++) begin
            ang  = PI * $itor(2 * k + 1) / $itor(4 * N);
            term = ang;
            sum  = ang;
            for (int n = 1; n <= 12; n++) begin
                term = -term * ang * ang / $itor(2 * n * (2 * n + 1));
                sum  = sum + term;
            end
            base = IDX_W'(k * SAMP_W);
            tbl[base +: SAMP_W] = SAMP_W'($rtoi(amp * sum + 0.5));
        end
        return tbl;
    endfunction

    localparam logic [ROM_BITS-1:0] ROM_TABLE = buildTable();

    logic                   w_unused_romFile;
    logic [ACC_W-1:0]       r_acc;
    logic [ACC_W-1:0]       r_freq;
    logic [THETA_W-1:0]     r_offset;
    logic [2:0]             r_fill;
    logic [THETA_W-1:0]     r_idx;
    logic [THETA_W-1:0]     r_idxAl;
    logic [1:0]             r_q;
    logic [SAMP_W-1:0]      r_romSin;
    logic [1:0]             w_q;
    logic [A_W-1:0]         w_a;
    logic [A_W-1:0]         w_addrSin;
    logic [IDX_W-1:0]       w_baseSin;
    logic [OUT_W-1:0]       w_magSin;

    assign w_unused_romFile = ^ROM_FILE;

    // Odd quadrants read the table mirrored: N-1-a is the bitwise complement of a.
    assign w_q       = r_idx[THETA_W-1 -: 2];
    assign w_a       = r_idx[A_W-1:0];
    assign w_addrSin = w_q[0] ? ~w_a : w_a;
    assign w_baseSin = IDX_W'(w_addrSin) * IDX_W'(SAMP_W);
    assign w_magSin  = {1'b0, r_romSin};
    assign o_valid   = r_fill[2];

`ifdef COS_OUTPUT_EN
    logic [1:0]             r_qCos;
    logic [SAMP_W-1:0]      r_romCos;
    logic [1:0]             w_qCos;
    logic [A_W-1:0]         w_addrCos;
    logic [IDX_W-1:0]       w_baseCos;
    logic [OUT_W-1:0]       w_magCos;

    assign w_qCos    = w_q + 2'd1;
    assign w_addrCos = w_qCos[0] ? ~w_a : w_a;
    assign w_baseCos = IDX_W'(w_addrCos) * IDX_W'(SAMP_W);
    assign w_magCos  = {1'b0, r_romCos};

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_qCos   <= '0;
            r_romCos <= '0;
            o_cosine <= '0;
        end else if (i_sync) begin
            r_qCos   <= '0;
            r_romCos <= '0;
        end else if (i_clkEn) begin
            r_qCos   <= w_qCos;
            r_romCos <= ROM_TABLE[w_baseCos +: SAMP_W];
            o_cosine <= r_qCos[1] ? -w_magCos : w_magCos;
        end
    end
`endif

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_freq   <= '0;
            r_offset <= '0;
        end else if (i_load) begin
            r_freq   <= i_freqWord;
            r_offset <= i_phaseOffset;
        end
    end

    // Sync restarts the run from phase zero but leaves the output samples holding until the pipe refills.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_acc    <= '0;
            r_fill   <= '0;
            r_idx    <= '0;
            r_idxAl  <= '0;
            r_q      <= '0;
            r_romSin <= '0;
            o_sine   <= '0;
            o_theta  <= '0;
        end else if (i_sync) begin
            r_acc    <= '0;
            r_fill   <= '0;
            r_idx    <= '0;
            r_idxAl  <= '0;
            r_q      <= '0;
            r_romSin <= '0;
        end else if (i_clkEn) begin
            r_acc    <= r_acc + r_freq;
            r_fill   <= {r_fill[1:0], 1'b1};
            r_idx    <= r_acc[ACC_W-1 -: THETA_W] + r_offset;
            r_idxAl  <= r_idx;
            r_q      <= w_q;
            r_romSin <= ROM_TABLE[w_baseSin +: SAMP_W];
            o_sine   <= r_q[1] ? -w_magSin : w_magSin;
            o_theta  <= r_idxAl;
        end
    end

endmodule

// File: tb/tb_param_sine_nco.sv
// Directed bench for param_sine_nco at default parameters; expected samples are hand-computed table values.
module tb_param_sine_nco;

    localparam int ROM0   = 25736;
    localparam int ROM1   = 77207;
    localparam int ROM255 = 8388568;

    logic               clock;
    logic               reset;
    logic               clkEn;
    logic               load;
    logic               sync;
    logic [31:0]        freqWord;
    logic [9:0]         phaseOffset;
    logic signed [23:0] sine;
    logic [9:0]         theta;
    logic               valid;
    int                 nAsserts;
    int                 nFails;
    longint             sineByTheta [1024];
`ifdef COS_OUTPUT_EN
    logic signed [23:0] cosine;
    longint             cosByTheta [1024];
`endif

    param_sine_nco dut (
        .i_clock       (clock),
        .i_reset       (reset),
        .i_clkEn       (clkEn),
        .i_load        (load),
        .i_freqWord    (freqWord),
        .i_phaseOffset (phaseOffset),
        .i_sync        (sync),
        .o_sine        (sine),
`ifdef COS_OUTPUT_EN
        .o_cosine      (cosine),
`endif
        .o_theta       (theta),
        .o_valid       (valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic applyStimulus(input logic en, input logic ld, input logic [31:0] fw,
                                 input logic [9:0] po, input logic sy);
        clkEn       = en;
        load        = ld;
        freqWord    = fw;
        phaseOffset = po;
        sync        = sy;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        nAsserts++;
        assert (observed === expected)
        else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    initial begin
        nAsserts = 0;
        nFails   = 0;
        reset    = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 10'd0, 1'b0);
        #2;
        checkOutput("reset sine", sine, 0);
        checkOutput("reset theta", theta, 0);
        checkOutput("reset valid", valid, 0);
        reset = 1'b0;

        // Short run, then reset in the middle of it.
        applyStimulus(1'b1, 1'b1, 32'h0040_0000, 10'd0, 1'b0);
        tick();
        load = 1'b0;
        repeat (5) tick();
        checkOutput("prerun theta", theta, 2);
        checkOutput("prerun valid", valid, 1);
        reset = 1'b1;
        #1;
        checkOutput("midreset sine", sine, 0);
        checkOutput("midreset theta", theta, 0);
        checkOutput("midreset valid", valid, 0);
        reset = 1'b0;

        applyStimulus(1'b1, 1'b1, 32'h0040_0000, 10'd0, 1'b0);
        tick();
        load = 1'b0;
        checkOutput("fill valid e1", valid, 0);
        tick();
        checkOutput("fill valid e2", valid, 0);
        tick();
        checkOutput("fill valid e3", valid, 1);
        checkOutput("first theta", theta, 0);
        checkOutput("first sine", sine, ROM0);
        sineByTheta[0] = sine;
`ifdef COS_OUTPUT_EN
        cosByTheta[0] = cosine;
`endif
        tick();
        checkOutput("repeat theta", theta, 0);

        // Full unit-step sweep, one index per enabled edge.
        for (int t = 1; t < 1024; t++) begin
            tick();
            checkOutput("sweep theta", theta, t);
            sineByTheta[t] = sine;
`ifdef COS_OUTPUT_EN
            cosByTheta[t] = cosine;
`endif
        end
        tick();
        checkOutput("wrap theta", theta, 0);
        checkOutput("wrap sine", sine, ROM0);

        checkOutput("sine 1", sineByTheta[1], ROM1);
        checkOutput("sine 255", sineByTheta[255], ROM255);
        checkOutput("sine 256", sineByTheta[256], ROM255);
        checkOutput("sine 510", sineByTheta[510], ROM1);
        checkOutput("sine 512", sineByTheta[512], -ROM0);
        checkOutput("sine 513", sineByTheta[513], -ROM1);
        checkOutput("sine 768", sineByTheta[768], -ROM255);
        checkOutput("sine 1022", sineByTheta[1022], -ROM1);
        for (int i = 0; i < 512; i++) begin
            checkOutput("half-wave antisymmetry", sineByTheta[i], -sineByTheta[i + 512]);
            checkOutput("quarter mirror", sineByTheta[i], sineByTheta[511 - i]);
        end
`ifdef COS_OUTPUT_EN
        checkOutput("cos 0", cosByTheta[0], ROM255);
        checkOutput("cos 256", cosByTheta[256], -ROM0);
        for (int i = 0; i < 1024; i++)
            checkOutput("cos quadrature", cosByTheta[i], sineByTheta[(i + 256) % 1024]);
`endif

        // Gating: two idle cycles must freeze everything and resume without skipping.
        clkEn = 1'b0;
        tick();
        checkOutput("gate theta a", theta, 0);
        tick();
        checkOutput("gate theta b", theta, 0);
        checkOutput("gate sine", sine, ROM0);
        checkOutput("gate valid", valid, 1);
        clkEn = 1'b1;
        tick();
        checkOutput("resume theta 1", theta, 1);
        tick();
        checkOutput("resume theta 2", theta, 2);

        // Offset loaded while idle takes effect after the pipe drains.
        applyStimulus(1'b0, 1'b1, 32'h0040_0000, 10'd256, 1'b0);
        tick();
        checkOutput("load idle theta", theta, 2);
        applyStimulus(1'b1, 1'b0, 32'h0040_0000, 10'd256, 1'b0);
        tick();
        checkOutput("offset a1", theta, 3);
        tick();
        checkOutput("offset a2", theta, 4);
        tick();
        checkOutput("offset a3", theta, 261);
        tick();
        checkOutput("offset a4", theta, 262);

        // Sync together with a new word: restart from zero stepping by two.
        applyStimulus(1'b1, 1'b1, 32'h0080_0000, 10'd0, 1'b1);
        tick();
        checkOutput("sync valid", valid, 0);
        checkOutput("sync theta hold", theta, 262);
        applyStimulus(1'b1, 1'b0, 32'h0080_0000, 10'd0, 1'b0);
        tick();
        checkOutput("sync valid b1", valid, 0);
        tick();
        checkOutput("sync valid b2", valid, 0);
        tick();
        checkOutput("sync valid b3", valid, 1);
        checkOutput("sync theta b3", theta, 0);
        checkOutput("sync sine b3", sine, ROM0);
        tick();
        checkOutput("sync theta b4", theta, 2);
        tick();
        checkOutput("sync theta b5", theta, 4);

        // Zero frequency word: output settles and stays constant.
        applyStimulus(1'b1, 1'b1, 32'h0, 10'd0, 1'b0);
        tick();
        load = 1'b0;
        checkOutput("zero fw c1", theta, 6);
        repeat (3) tick();
        checkOutput("zero fw c4", theta, 12);
        tick();
        checkOutput("zero fw c5", theta, 12);
        tick();
        checkOutput("zero fw c6", theta, 12);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule

// File: doc/param_sine_nco.md
Name: param_sine_nco

Overview:
Parametrised numerically controlled sine source.
- Phase accumulator drives a quarter-wave symmetric sine ROM.
- Outputs a signed sine sample each enabled cycle, with programmable frequency word, phase offset and resync.
- Successor to the fixed 10-bit-theta sine table. Feeds the slice DSP path as an on-chip test tone and carrier.

Parameters:
ACC_W, 32, phase accumulator width in bits
THETA_W, 10, full-circle table index width (>=4); quarter table depth N = 2^(THETA_W-2)
OUT_W, 24, signed output sample width
ROM_FILE, "sine_quarter.mem", $readmemh image: N entries, unsigned, OUT_W-1 bits

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
ClkEn  in  1  pipeline/accumulator advance enable
Load  in  1  capture FreqWord and PhaseOffset
FreqWord  in  ACC_W  phase increment per enabled cycle
PhaseOffset  in  THETA_W  phase offset added at index level
Sync  in  1  synchronous accumulator clear and pipeline flush
Sine  out  OUT_W  signed sine sample
Theta  out  THETA_W  table index aligned with Sine
Valid  out  1  Sine holds a sample from the current run

Behaviour:
- Interface decision: one clock, Clock. Reset is asynchronous, active-high. Reset asserted forces all registers to 0 immediately (acc, freq_reg, offset_reg, pipeline, Sine=0, Theta=0, Valid=0). This includes reset mid-operation.
- ROM content: rom[k] = round((2^(OUT_W-1)-1)*sin(2*pi*(k+0.5)/2^THETA_W)), k=0..N-1. Half-sample offset makes mirroring exact. Output is never exactly 0.
- Load: captures FreqWord into freq_reg and PhaseOffset into offset_reg on any rising edge, independent of ClkEn. New values are used from the next enabled edge.
- Accumulator: on each edge with ClkEn=1, acc <= acc + freq_reg, wrapping modulo 2^ACC_W. ClkEn=0 holds acc and the whole pipeline, including Valid.
- Stage 1 (enabled edge n): idx_r <= acc[ACC_W-1 -: THETA_W] + offset_reg, mod 2^THETA_W. Uses the pre-update acc.
- Stage 2: q = idx_r[THETA_W-1:THETA_W-2], a = idx_r[THETA_W-3:0].
  - ROM address = a for q=0 and q=2.
  - ROM address = N-1-a for q=1 and q=3.
  - rom_r, q_r and idx pipe register together.
- Stage 3: Sine <= +rom_r for q in {0,1} and -rom_r for q in {2,3}, as two's complement in OUT_W. No overflow is possible. Theta <= aligned idx.
- Latency: the acc value present before enabled edge n appears on Sine after enabled edge n+2, i.e. 3 enabled edges.
- Valid: a 3-bit fill shift register, shifted on enabled edges. Valid rises on the 3rd enabled edge after Reset release or Sync, then stays high.
- Sync: synchronous, acted on regardless of ClkEn, priority over accumulate. acc <= 0, fill register cleared, so Valid=0 on the next edge. Sine/Theta hold until refilled.
- Load and Sync on the same edge: both take effect. The first enabled step after that edge accumulates the new freq_reg from acc=0.
- FreqWord = 2^(ACC_W-THETA_W) steps the index by exactly 1 per enabled cycle. FreqWord = 0 gives a constant output.

Optional Feature:
COS_OUTPUT_EN
- Defined: adds output port Cosine [OUT_W] (signed, reset 0). Cosine = sample at index idx_r + N, mod 2^THETA_W. It uses a second ROM read port with the same quadrant rules, is pipeline-aligned with Sine, and shares Valid.
- Undefined: Cosine port and second read path are absent; Sine behaviour is identical.

Test Plan:
- Reset check (defaults, THETA_W=10, OUT_W=24): assert Reset mid-stream -> Sine=0, Theta=0 and Valid=0 immediately. After release with ClkEn=1, Load FreqWord=0x00400000, Valid rises on the 3rd enabled edge.
- Unit-step sweep: FreqWord=0x00400000, PhaseOffset=0 -> Theta=0,1,2,... one per cycle.
  - Sine(Theta=0)=25736; Sine(512)=-25736; Sine(256)=rom[255]; Sine(768)=-rom[255].
  - Sine(i) = -Sine(i+512) for all i; Sine(i) = Sine(511-i) for i<512.
  - Theta wraps 1023 -> 0.
- ClkEn gating: toggle ClkEn 1,0,0,1 -> Sine, Theta, acc and Valid frozen during the 0 cycles; sequence resumes without a skipped or repeated index.
- Offset and Load: PhaseOffset=256 loaded mid-run with ClkEn=0 -> after 3 enabled edges, Theta jumps by +256. The step rate is unchanged.
- Sync with simultaneous Load (FreqWord=0x00800000) -> Valid=0 next edge. After 3 enabled edges, Valid=1 and Theta=0,2,4,...
- COS_OUTPUT_EN build -> Cosine(Theta=0)=rom[255]; Cosine(Theta=256)=-25736; Cosine(i) = Sine(i+256) for all i.
